// File: rtl/wyswietlacz_mux_if.sv
// wyswietlacz_mux_if: data, control and display-pin signals of the multiplexed 7-segment driver
interface wyswietlacz_mux_if #(
    parameter int N_CYFR = 4
);
    logic [4*N_CYFR-1:0] dane;
    logic [N_CYFR-1:0]   kropki;
    logic                zapisz;
    logic                wygas_zera;
    logic [3:0]          jasnosc;
    logic [6:0]          seg;
    logic                dp;
    logic [N_CYFR-1:0]   anody;
    logic                ramka;
    modport master (output dane, kropki, zapisz, wygas_zera, jasnosc, input seg, dp, anody, ramka);
    modport slave (input dane, kropki, zapisz, wygas_zera, jasnosc, output seg, dp, anody, ramka);
endinterface

// File: rtl/wyswietlacz_mux.sv
// wyswietlacz_mux: time-multiplexed N-digit hex display driver with double buffering, blanking and PWM
module wyswietlacz_mux #(
    parameter int N_CYFR = 4,
    parameter int DZIELNIK = 1000
) (
    input logic clk,
    input logic rst_n,
    wyswietlacz_mux_if.slave bus
);
    localparam int PW = $clog2(DZIELNIK);
    localparam int IW = N_CYFR > 1 ? $clog2(N_CYFR) : 1;
    localparam int WW = PW + 5;
    localparam logic [15:0][6:0] HEX = {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
                                        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
    logic [PW-1:0]       p;
    logic [IW-1:0]       i;
    logic [4*N_CYFR-1:0] pend_d, disp_d;
    logic [N_CYFR-1:0]   pend_k, disp_k, zr, an_n;
    logic [3:0]          nib;
    logic [6:0]          seg_n;
    logic [WW-1:0]       lhs, rhs;
    logic                koniec, ramka, lit, z;
    always_comb begin
        koniec = p == PW'(DZIELNIK - 1);
        ramka = koniec && i == IW'(N_CYFR - 1);
        nib = disp_d[{i, 2'b00} +: 4];
        z = 1'b1;
        zr = '0;
        for (int k = N_CYFR - 1; k >= 0; k--) begin
            z = z && disp_d[4*k +: 4] == 4'd0;
            zr[k] = z;
        end
        seg_n = (bus.wygas_zera && i != '0 && zr[i]) ? 7'h7F : HEX[nib];
        lhs = WW'(p) << 4;
        rhs = (WW'(bus.jasnosc) + WW'(1)) * WW'(DZIELNIK);
        // prescaler 0 is the dead cycle between digits
        lit = p != '0 && lhs < rhs;
        an_n = lit ? ~(N_CYFR'(1) << i) : '1;
    end
    assign bus.ramka = ramka;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p <= '0;
            i <= '0;
            pend_d <= '0;
            pend_k <= '0;
            disp_d <= '0;
            disp_k <= '0;
            bus.seg <= 7'h7F;
            bus.dp <= 1'b1;
            bus.anody <= '1;
        end else begin
            p <= koniec ? '0 : p + PW'(1);
            if (koniec) i <= ramka ? '0 : i + IW'(1);
            if (bus.zapisz) begin
                pend_d <= bus.dane;
                pend_k <= bus.kropki;
            end
            if (ramka) begin
                disp_d <= bus.zapisz ? bus.dane : pend_d;
                disp_k <= bus.zapisz ? bus.kropki : pend_k;
            end
            bus.seg <= seg_n;
            bus.dp <= ~disp_k[i];
            bus.anody <= an_n;
        end
    end
endmodule
